// File: rtl/systolic_matrix_loader_if.sv
// rtl/systolic_matrix_loader_if.sv - element stream into the systolic matrix loader
interface systolic_matrix_loader_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;

    modport master (output i_data, output i_valid, output i_last, input o_ready);
    modport slave  (input i_data, input i_valid, input i_last, output o_ready);
endinterface

// File: rtl/systolic_matrix_loader.sv
// rtl/systolic_matrix_loader.sv - assembles an A-then-B byte stream into NxN operands and fires the array
// Optional framing check on i_last: LOADER_ERR_CHECK_EN.
module systolic_matrix_loader #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    systolic_matrix_loader_if.slave      s_in,
    output logic [N-1:0][N-1:0][DW-1:0]  o_a,
    output logic [N-1:0][N-1:0][DW-1:0]  o_b,
    output logic                         o_validInput,
    input  logic                         i_validResult,
    output logic                         o_busy,
    output logic                         o_err
);
    localparam int             NN   = N * N;
    localparam int             CW   = $clog2(2 * NN);
    localparam logic [CW-1:0]  LAST = CW'(2 * NN - 1);

    typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [CW-1:0]                 r_cnt;
    logic [N-1:0][N-1:0][DW-1:0]   r_a;
    logic [N-1:0][N-1:0][DW-1:0]   r_b;
    logic                          w_ready;
    logic                          w_xfer;
    logic                          w_end;
    logic                          w_bad;

    assign w_xfer = s_in.i_valid & w_ready;
    assign w_end  = (r_cnt == LAST);

`ifdef LOADER_ERR_CHECK_EN
    logic r_err;

    // A beat whose i_last disagrees with its position drops the whole frame.
    assign w_bad = w_xfer & (s_in.i_last != w_end);

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_err <= 1'b0;
        end else if (w_bad) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_last;

    assign w_unused_last = s_in.i_last;
    assign w_bad         = 1'b0;
    assign o_err         = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ready      = 1'b0;
        o_validInput = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ready = ~i_arst;
                if (w_xfer && w_end && !w_bad) begin
                    w_next = S_FIRE;
                end
            end
            S_FIRE: begin
                o_validInput = 1'b1;
                o_busy       = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (i_validResult) begin
                    w_next = S_LOAD;
                end
            end
            default: begin
                w_next = S_LOAD;
            end
        endcase
    end

    assign s_in.o_ready = w_ready;

    // Transfers only happen in LOAD, so the operands are frozen while the array works.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_xfer) begin
            if (w_bad || w_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (!w_bad) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        if (r_cnt == CW'(r * N + c)) begin
                            r_a[r][c] <= s_in.i_data;
                        end
                        if (r_cnt == CW'(NN + r * N + c)) begin
                            r_b[r][c] <= s_in.i_data;
                        end
                    end
                end
            end
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;
endmodule
